// File: rtl/tag_responder.sv
// tag_responder: in-order tagged read responder with fixed latency.
// Flags a tag that is issued again while it is still outstanding.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   i_req_*         request: valid/ready, effective address, tag
//   o_rsp_*         response: valid/ready, tag, data (ea + slice index)
//   o_cnt           number of outstanding requests
//   o_err_dup       sticky duplicate-outstanding-tag flag
module tag_responder #(
  parameter int addr_width  = 64,
  parameter int data_width  = 1024,
  parameter int tag         = 256,
  parameter int tag_width   = $clog2(tag),
  parameter int depth       = 8,
  parameter int depth_width = $clog2(depth),
  parameter int latency     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_req_v,
  output logic                   i_req_r,
  input  logic [addr_width-1:0]  i_req_ea,
  input  logic [tag_width-1:0]   i_req_tag,
  output logic                   o_rsp_v,
  input  logic                   o_rsp_r,
  output logic [tag_width-1:0]   o_rsp_tag,
  output logic [data_width-1:0]  o_rsp_data,
  output logic [depth_width:0]   o_cnt,
  output logic                   o_err_dup
);

  localparam int tmr_width =
    (latency > 1) ? $clog2(latency) : 1;
  localparam int slices = data_width / addr_width;
  localparam logic [tmr_width-1:0] tmr_init =
    tmr_width'(latency - 1);
  localparam logic [depth_width:0] cnt_full =
    (depth_width + 1)'(depth);

  logic [addr_width-1:0]  ea_q  [depth];
  logic [addr_width-1:0]  ea_d  [depth];
  logic [tag_width-1:0]   tag_q [depth];
  logic [tag_width-1:0]   tag_d [depth];
  logic [tmr_width-1:0]   tmr_q [depth];
  logic [tmr_width-1:0]   tmr_d [depth];
  logic [depth_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [depth_width:0]   cnt_q, cnt_d;
  logic [tag-1:0]         bitmap_q, bitmap_d;
  logic                   err_q, err_d;

  logic                   push, pop;
  logic [addr_width-1:0]  head_ea;
  logic [tag_width-1:0]   head_tag;
  logic [tmr_width-1:0]   head_tmr;

  assign head_ea  = ea_q[rd_ptr_q];
  assign head_tag = tag_q[rd_ptr_q];
  assign head_tmr = tmr_q[rd_ptr_q];

  // Ready/valid are gated by reset so both read 0
  // for the whole time reset is held.
  assign i_req_r = reset & (cnt_q < cnt_full);
  assign o_rsp_v = reset & (cnt_q != '0)
                 & (head_tmr == '0);

  assign push = i_req_v & i_req_r;
  assign pop  = o_rsp_v & o_rsp_r;

  assign o_rsp_tag = o_rsp_v ? head_tag : '0;
  assign o_cnt     = cnt_q;
  assign o_err_dup = err_q;

  for (genvar g = 0; g < slices; g++) begin : g_slice
    assign o_rsp_data[g*addr_width +: addr_width] =
      o_rsp_v ? head_ea + addr_width'(g) : '0;
  end

  always_comb begin
    ea_d     = ea_q;
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bitmap_d = bitmap_q;
    err_d    = err_q;
    for (int i = 0; i < depth; i++) begin
      tmr_d[i] = tmr_q[i];
      if (tmr_q[i] != '0) tmr_d[i] = tmr_q[i] - 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      bitmap_d[head_tag] = 1'b0;
    end
    if (push) begin
      ea_d[wr_ptr_q]  = i_req_ea;
      tag_d[wr_ptr_q] = i_req_tag;
      tmr_d[wr_ptr_q] = tmr_init;
      wr_ptr_d = wr_ptr_q + 1'b1;
      // Checked after the pop clear, so a same-cycle
      // retire and reissue of one tag is legal.
      if (bitmap_d[i_req_tag]) err_d = 1'b1;
      bitmap_d[i_req_tag] = 1'b1;
    end
    cnt_d = cnt_q + (depth_width + 1)'(push)
                  - (depth_width + 1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        ea_q[i]  <= '0;
        tag_q[i] <= '0;
        tmr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      ea_q     <= ea_d;
      tag_q    <= tag_d;
      tmr_q    <= tmr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/tag_responder.md
# tag_responder

Memory-side responder for the tagged request/response protocol used by the stream cache tag interface. It accepts tagged read requests (effective address plus tag), holds up to `depth` of them in an in-order buffer, and returns each response (tag plus deterministic data) exactly `latency` cycles after acceptance, or later under backpressure. It sits opposite the tag-issuing initiator, both in the L2 testbench and as the stand-in for the OpenCAPI host side. It also flags protocol violations where a tag is issued again while still outstanding.

## Interface
- `addr_width`, 64, request effective-address width.
- `data_width`, 1024, response data width; must be an integer multiple of `addr_width`.
- `tag`, 256, number of distinct tags.
- `tag_width`, `$clog2(tag)`, tag field width.
- `depth`, 8, maximum number of outstanding requests; a power of two and at least 2.
- `depth_width`, `$clog2(depth)`, buffer pointer width.
- `latency`, 4, minimum request-to-response delay in cycles; at least 1.

Ports:
- `clk`, input, 1, the single clock.
- `reset`, input, 1. Reset is asynchronous and active-low: asserted when 0.
- `i_req_v`, input, 1, request valid.
- `i_req_r`, output, 1, request ready.
- `i_req_ea`, input, `addr_width`, request effective address.
- `i_req_tag`, input, `tag_width`, request tag.
- `o_rsp_v`, output, 1, response valid.
- `o_rsp_r`, input, 1, response ready.
- `o_rsp_tag`, output, `tag_width`, response tag.
- `o_rsp_data`, output, `data_width`, response data.
- `o_cnt`, output, `depth_width+1`, number of outstanding requests.
- `o_err_dup`, output, 1, sticky flag: a duplicate outstanding tag was accepted.

## Operation
- Handshakes are valid/ready.
  - A request transfers when `i_req_v & i_req_r`.
  - A response transfers when `o_rsp_v & o_rsp_r`.
  - A valid signal may not depend on the matching ready.
- Buffer: circular FIFO of `depth` entries. Each entry holds {ea, tag, timer}.
  - Write and read pointers are `depth_width` bits and wrap naturally.
  - `o_cnt` is the occupancy, from 0 to `depth`.
- Acceptance:
  - `i_req_r = (o_cnt < depth)`.
  - There is no same-cycle bypass of a pop. When the buffer is full, `i_req_r` stays 0 even if a pop happens in that cycle.
- Timer:
  - On acceptance the entry's timer is loaded with `latency-1`.
  - Every entry with a nonzero timer decrements on every clock edge, independent of backpressure.
- Response:
  - `o_rsp_v = (o_cnt != 0) & (head timer == 0)`.
  - Responses are returned strictly in acceptance order.
  - `o_rsp_tag` is the head tag.
  - `o_rsp_data` slice i (bits `[i*addr_width +: addr_width]`) equals `head_ea + i` modulo 2^`addr_width`, for i = 0 .. `data_width/addr_width - 1`.
- Tag tracking: a `tag`-bit outstanding bitmap.
  - The bit is set on request transfer and cleared on response transfer.
  - If a request transfers while its tag bit is set (after applying a same-cycle clear), `o_err_dup` is set and stays set until reset. The request is still accepted and answered.
  - A same-cycle pop and push of the same tag is not an error; the bit ends set.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Both pointers advance.
  - Timers of other entries continue decrementing.

## Timing
- Reset (`reset`=0) acts immediately and asynchronously:
  - `o_rsp_v`=0, `i_req_r`=0, `o_cnt`=0, `o_err_dup`=0.
  - `o_rsp_tag` and `o_rsp_data` are 0.
  - Pointers, timers and bitmap are cleared.
- After reset release, `i_req_r`=1 in the first cycle.
- If reset is asserted mid-operation, all outstanding entries are discarded. No stale response appears after release.
- Latency:
  - A request transferred in cycle t produces `o_rsp_v`=1 no earlier than cycle t+`latency`.
  - It is exactly t+`latency` if its entry is at the head and no earlier response is stalled.
- Throughput: one request and one response per cycle sustained.
- Backpressure:
  - While `o_rsp_r`=0, `o_rsp_v`, `o_rsp_tag` and `o_rsp_data` hold stable.
  - Stalled entries behind the head reach timer 0 and then leave in consecutive cycles once `o_rsp_r` rises.
- `o_cnt` and `o_err_dup` are registered and update on the edge ending the transfer cycle.

## Test plan
- Single request, `latency`=4: at cycle 10 send ea=0x1000, tag=5, with `o_rsp_r`=1. Expect `o_rsp_v`=1 only in cycle 14, tag=5, slice0=0x1000, slice1=0x1001, slice15=0x100F. `o_cnt` reads 1 from cycle 11 to 14 and 0 from cycle 15.
- Full buffer: send 9 back-to-back requests (tags 0-8) with `o_rsp_r`=0. Expect 8 accepted, `i_req_r`=0 once `o_cnt`=8, and tag 8 held. Raise `o_rsp_r`: expect tags 0-7 in 8 consecutive cycles, `i_req_r` returning to 1 the cycle after the first pop, and tag 8 accepted then.
- Duplicate tag: send tag 3 at cycle 0 and tag 3 again at cycle 1. Expect `o_err_dup`=1 from cycle 2 and sticky; both responses return with tag 3.
- Legal reuse: send tag 7, and resend tag 7 in the same cycle its response transfers. Expect `o_err_dup` to stay 0.
- Reset mid-operation: with 3 outstanding, pulse `reset`=0 for 2 cycles. Expect `o_rsp_v`=0 and `o_cnt`=0 immediately, and no responses for 10 cycles after release.
- Wrap-around: 40 requests with random `i_req_v` and `o_rsp_r` toggling. Expect all 40 tags returned in order with correct data and at least `latency` cycles each, and `o_cnt` back at 0.
